// File: rtl/gb_bus_arbiter.sv
// Bus arbiter between the CPU core and the system buses: M-cycle phase generator,
// CPU access routing (main bus / HRAM / FF46) and the OAM DMA engine.
module gb_bus_arbiter #(
  parameter int unsigned DMA_LEN      = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [1:0]  t_phase,
  input  logic [2:0]  cpu_op,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  hram_addr,
  output logic        hram_rd,
  output logic        hram_we,
  output logic [7:0]  hram_wdata,
  input  logic [7:0]  hram_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  // state | meaning
  // IDLE  | no transfer in progress
  // SETUP | one M-cycle gap after an FF46 write; CPU still owns the main bus
  // RUN   | DMA reads {dma_reg, dma_idx} each M-cycle; CPU main-bus accesses blocked
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_IF    = 3'd1;
  localparam logic [2:0] OP_IF_CB = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_WRITE = 3'd4;

  localparam logic [7:0] DMA_LAST = 8'(DMA_LEN - 1);

  logic [1:0] r_tphase;
  logic [1:0] r_state;
  logic [7:0] r_dma_reg;
  logic [7:0] r_dma_idx;
  logic [7:0] r_rdata;
  logic       r_rvalid;
  logic       r_oam_we;
  logic [7:0] r_oam_addr;
  logic [7:0] r_oam_wdata;

  logic       w_mend;
  logic       w_ph2;
  logic       w_run;
  logic       w_is_rd;
  logic       w_is_wr;
  logic       w_sel_reg;
  logic       w_sel_hram;
  logic       w_sel_main;
  logic       w_trig;
  logic [7:0] w_rd_src;

  assign w_mend     = (r_tphase == 2'd3);
  assign w_ph2      = (r_tphase == 2'd2);
  assign w_run      = (r_state == S_RUN);
  assign w_is_rd    = (cpu_op == OP_IF) || (cpu_op == OP_IF_CB) || (cpu_op == OP_READ);
  assign w_is_wr    = (cpu_op == OP_WRITE);
  assign w_sel_reg  = (cpu_addr == DMA_REG_ADDR);
  assign w_sel_hram = !w_sel_reg && (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
  assign w_sel_main = !w_sel_reg && !w_sel_hram && !w_run;
  assign w_trig     = w_is_wr && w_sel_reg;

  // Blocked main-bus reads during RUN return open-bus 0xFF.
  always_comb begin
    w_rd_src = 8'hFF;
    if (w_sel_reg)
      w_rd_src = r_dma_reg;
    else if (w_sel_hram)
      w_rd_src = hram_rdata;
    else if (w_sel_main)
      w_rd_src = mem_rdata;
  end

  assign t_phase    = r_tphase;
  assign cpu_rdata  = r_rdata;
  assign cpu_rvalid = r_rvalid;
  assign dma_active = w_run;

  assign mem_addr   = w_run ? {r_dma_reg, r_dma_idx} : cpu_addr;
  assign mem_rd     = w_run || (w_sel_main && w_is_rd);
  assign mem_wr     = w_sel_main && w_is_wr && w_ph2;
  assign mem_wdata  = cpu_wdata;

  assign hram_addr  = cpu_addr[6:0];
  assign hram_rd    = w_sel_hram && w_is_rd;
  assign hram_we    = w_sel_hram && w_is_wr && w_ph2;
  assign hram_wdata = cpu_wdata;

  assign oam_we     = r_oam_we;
  assign oam_addr   = r_oam_addr;
  assign oam_wdata  = r_oam_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tphase <= 2'd0;
    else
      r_tphase <= r_tphase + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= 8'hFF;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_mend && w_is_rd) begin
        r_rdata  <= w_rd_src;
        r_rvalid <= 1'b1;
      end
    end
  end

  // A retrigger abandons the byte being read in that M-cycle; the previous byte's
  // OAM write was already launched at the preceding boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dma_reg   <= 8'hFF;
      r_dma_idx   <= 8'd0;
      r_oam_we    <= 1'b0;
      r_oam_addr  <= 8'd0;
      r_oam_wdata <= 8'd0;
    end else begin
      r_oam_we <= 1'b0;
      if (w_mend) begin
        if (w_run && !w_trig) begin
          r_oam_we    <= 1'b1;
          r_oam_addr  <= r_dma_idx;
          r_oam_wdata <= mem_rdata;
        end
        if (w_trig) begin
          r_dma_reg <= cpu_wdata;
          r_state   <= S_SETUP;
          r_dma_idx <= 8'd0;
        end else begin
          case (r_state)
            S_SETUP: begin
              r_state   <= S_RUN;
              r_dma_idx <= 8'd0;
            end
            S_RUN: begin
              r_dma_idx <= r_dma_idx + 8'd1;
              if (r_dma_idx == DMA_LAST)
                r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gb_bus_arbiter.sv
// Self-checking bench for gb_bus_arbiter: vector table, DMA corner sequences and
// randomized traffic compared against an M-cycle-level reference model.
module tb_gb_bus_arbiter;

  localparam int DMA_LEN = 160;
  localparam logic [2:0] OP_IDLE = 3'd0, OP_IF = 3'd1, OP_IFCB = 3'd2, OP_READ = 3'd3, OP_WRITE = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  t_phase;
  logic [2:0]  cpu_op = OP_IDLE;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [6:0]  hram_addr;
  logic        hram_rd, hram_we;
  logic [7:0]  hram_wdata, hram_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr, oam_wdata;
  logic        dma_active;

  always #5 clk = ~clk;

  gb_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .t_phase(t_phase),
    .cpu_op(cpu_op), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hram_addr(hram_addr), .hram_rd(hram_rd), .hram_we(hram_we),
    .hram_wdata(hram_wdata), .hram_rdata(hram_rdata),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .dma_active(dma_active)
  );

  function automatic logic [7:0] bus_model(input logic [15:0] a);
    return (a == 16'h0150) ? 8'h3E : (a[7:0] ^ 8'hA5);
  endfunction

  function automatic logic [7:0] hram_model(input logic [6:0] a);
    return {1'b0, a} ^ 8'h5C;
  endfunction

  assign mem_rdata  = bus_model(mem_addr);
  assign hram_rdata = hram_model(hram_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a DMA is described only by the M-cycle in which its SETUP falls.
  int         m;
  bit         md_valid;
  int         md_start;
  logic [7:0] md_reg;
  bit         pv_active, pv_trig;
  int         pv_idx;
  logic [7:0] pv_src;
  bit         exp_rv;
  logic [7:0] exp_rdata;
  int         n_act, n_oam;

  logic [7:0]  o_ph;
  logic [3:0]  o_mrd, o_mwr, o_hrd, o_hwe, o_act, o_oamwe, o_rv;
  logic [15:0] o_maddr [4];
  logic [7:0]  o_oaddr, o_odata, o_rdata;

  task automatic model_reset();
    m = 0; md_valid = 0; md_start = 0; md_reg = 8'hFF;
    pv_active = 0; pv_trig = 0; pv_idx = 0; pv_src = 8'h00;
    exp_rv = 0; exp_rdata = 8'hFF;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tphase"}, t_phase, 2'd0);
    chk({tag, "_strobes"}, {mem_rd, mem_wr, hram_rd, hram_we, oam_we, cpu_rvalid, dma_active}, 7'd0);
    chk({tag, "_rdata"}, cpu_rdata, 8'hFF);
    chk({tag, "_oam"}, {oam_addr, oam_wdata}, 16'h0000);
  endtask

  // Entered #1 after the edge that starts phase 0; returns at the same point one M-cycle later.
  task automatic mcycle(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd);
    bit act, is_rd, is_wr, sel_reg, sel_hram, sel_main, trig, oam_exp;
    int idx;
    logic [3:0] e_mrd, e_mwr, e_hrd, e_hwe;
    cpu_op = op; cpu_addr = addr; cpu_wdata = wd;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      o_ph[2*p +: 2] = t_phase;
      o_mrd[p] = mem_rd; o_mwr[p] = mem_wr; o_hrd[p] = hram_rd; o_hwe[p] = hram_we;
      o_act[p] = dma_active; o_oamwe[p] = oam_we; o_rv[p] = cpu_rvalid;
      o_maddr[p] = mem_addr;
      if (p == 0) begin
        o_oaddr = oam_addr; o_odata = oam_wdata; o_rdata = cpu_rdata;
      end
      @(posedge clk); #1;
    end
    idx      = m - md_start - 1;
    act      = md_valid && idx >= 0 && idx < DMA_LEN;
    is_rd    = (op == OP_IF) || (op == OP_IFCB) || (op == OP_READ);
    is_wr    = (op == OP_WRITE);
    sel_reg  = (addr == 16'hFF46);
    sel_hram = (addr >= 16'hFF80) && (addr <= 16'hFFFE);
    sel_main = !sel_reg && !sel_hram && !act;
    e_mrd = (act || (sel_main && is_rd)) ? 4'hF : 4'h0;
    e_mwr = (sel_main && is_wr) ? 4'b0100 : 4'h0;
    e_hrd = (sel_hram && is_rd) ? 4'hF : 4'h0;
    e_hwe = (sel_hram && is_wr) ? 4'b0100 : 4'h0;
    chk("t_phase_seq", o_ph, 8'b11_10_01_00);
    chk("mem_rd", o_mrd, e_mrd);
    chk("mem_wr", o_mwr, e_mwr);
    chk("hram_rd", o_hrd, e_hrd);
    chk("hram_we", o_hwe, e_hwe);
    chk("dma_active", o_act, act ? 4'hF : 4'h0);
    if (act) begin
      for (int p = 0; p < 4; p++) chk("dma_mem_addr", o_maddr[p], {md_reg, idx[7:0]});
    end else if (sel_main && (is_rd || is_wr)) begin
      chk("cpu_mem_addr", o_maddr[1], addr);
    end
    if (sel_main && is_wr) chk("mem_wdata", mem_wdata, wd);
    if (sel_hram && (is_rd || is_wr)) chk("hram_addr", hram_addr, addr[6:0]);
    if (sel_hram && is_wr) chk("hram_wdata", hram_wdata, wd);
    oam_exp = pv_active && !pv_trig;
    chk("oam_we", o_oamwe, oam_exp ? 4'b0001 : 4'h0);
    if (oam_exp) begin
      chk("oam_addr", o_oaddr, pv_idx);
      chk("oam_wdata", o_odata, bus_model({pv_src, pv_idx[7:0]}));
    end
    chk("cpu_rvalid", o_rv, exp_rv ? 4'b0001 : 4'h0);
    chk("cpu_rdata", o_rdata, exp_rdata);
    if (o_act == 4'hF) n_act++;
    if (o_oamwe[0]) n_oam++;
    trig = is_wr && sel_reg;
    pv_active = act; pv_trig = trig; pv_idx = idx; pv_src = md_reg;
    exp_rv = is_rd;
    if (is_rd)
      exp_rdata = sel_reg ? md_reg : sel_hram ? hram_model(addr[6:0]) : act ? 8'hFF : bus_model(addr);
    if (trig) begin
      md_reg = wd; md_start = m + 1; md_valid = 1;
    end
    m++;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [3:0]  mrd, mwr, hrd, hwe;
    logic        rv;
    logic [7:0]  rdata;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int unsigned r;
    logic [2:0]  rop;
    logic [15:0] raddr;
    bit          p_rv;
    logic [7:0]  p_rdata;

    tbl[0] = '{OP_READ,  16'h0150, 8'h00, 4'hF, 4'h0,    4'h0, 4'h0,    1'b1, 8'h3E};
    tbl[1] = '{OP_WRITE, 16'hC000, 8'h5A, 4'h0, 4'b0100, 4'h0, 4'h0,    1'b0, 8'h3E};
    tbl[2] = '{OP_IF,    16'h0200, 8'h00, 4'hF, 4'h0,    4'h0, 4'h0,    1'b1, 8'hA5};
    tbl[3] = '{OP_IFCB,  16'hFF85, 8'h00, 4'h0, 4'h0,    4'hF, 4'h0,    1'b1, 8'h59};
    tbl[4] = '{OP_WRITE, 16'hFF90, 8'h77, 4'h0, 4'h0,    4'h0, 4'b0100, 1'b0, 8'h59};
    tbl[5] = '{OP_READ,  16'hFFFF, 8'h00, 4'hF, 4'h0,    4'h0, 4'h0,    1'b1, 8'h5A};
    tbl[6] = '{OP_READ,  16'hFF7F, 8'h00, 4'hF, 4'h0,    4'h0, 4'h0,    1'b1, 8'hDA};
    tbl[7] = '{3'd5,     16'h0150, 8'h00, 4'h0, 4'h0,    4'h0, 4'h0,    1'b0, 8'hDA};
    tbl[8] = '{OP_READ,  16'hFF46, 8'h00, 4'h0, 4'h0,    4'h0, 4'h0,    1'b1, 8'hFF};
    tbl[9] = '{OP_IDLE,  16'h0000, 8'h00, 4'h0, 4'h0,    4'h0, 4'h0,    1'b0, 8'hFF};

    model_reset();
    repeat (3) @(posedge clk);
    #2 chk_reset_vals("reset");
    release_reset();

    // Vector table on an idle bus.
    p_rv = 0; p_rdata = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      mcycle(tbl[i].op, tbl[i].addr, tbl[i].wd);
      chk("tbl_mem_rd", o_mrd, tbl[i].mrd);
      chk("tbl_mem_wr", o_mwr, tbl[i].mwr);
      chk("tbl_hram_rd", o_hrd, tbl[i].hrd);
      chk("tbl_hram_we", o_hwe, tbl[i].hwe);
      chk("tbl_rvalid", o_rv[0], p_rv);
      chk("tbl_rdata", o_rdata, p_rdata);
      p_rv = tbl[i].rv; p_rdata = tbl[i].rdata;
    end

    // Full DMA from C1xx with CPU traffic during RUN.
    n_act = 0; n_oam = 0;
    mcycle(OP_WRITE, 16'hFF46, 8'hC1);
    mcycle(OP_IDLE, 16'h0000, 8'h00);
    chk("setup_inactive", o_act, 4'h0);
    for (int i = 0; i < DMA_LEN + 2; i++) begin
      case (i)
        10: mcycle(OP_READ, 16'h8000, 8'h00);
        11: begin
          mcycle(OP_WRITE, 16'hFF90, 8'h77);
          chk("run_read_8000", o_rdata, 8'hFF);
          chk("run_hram_we", o_hwe, 4'b0100);
        end
        20: mcycle(OP_READ, 16'hFF46, 8'h00);
        21: begin
          mcycle(OP_IDLE, 16'h0000, 8'h00);
          chk("run_read_ff46", o_rdata, 8'hC1);
        end
        default: mcycle(OP_IDLE, 16'h0000, 8'h00);
      endcase
      if (i == 0) chk("first_dma_addr", o_maddr[0], 16'hC100);
      if (i == DMA_LEN - 1) chk("last_dma_addr", o_maddr[0], 16'hC19F);
    end
    chk("dma_active_mcycles", n_act, DMA_LEN);
    chk("oam_pulse_count", n_oam, DMA_LEN);

    // Retrigger with D0 while byte 50 is being read.
    mcycle(OP_WRITE, 16'hFF46, 8'hC1);
    mcycle(OP_IDLE, 16'h0000, 8'h00);
    for (int i = 0; i < 50; i++) mcycle(OP_IDLE, 16'h0000, 8'h00);
    mcycle(OP_WRITE, 16'hFF46, 8'hD0);
    chk("retrig_addr", o_maddr[0], 16'hC132);
    chk("retrig_oam49_we", o_oamwe, 4'b0001);
    chk("retrig_oam49_addr", o_oaddr, 8'd49);
    mcycle(OP_IDLE, 16'h0000, 8'h00);
    chk("retrig_setup_inactive", o_act, 4'h0);
    chk("retrig_no_oam50", o_oamwe, 4'h0);
    mcycle(OP_IDLE, 16'h0000, 8'h00);
    chk("retrig_restart_addr", o_maddr[0], 16'hD000);
    for (int i = 0; i < DMA_LEN + 1; i++) mcycle(OP_IDLE, 16'h0000, 8'h00);

    // Reset asserted in phase 1 of the M-cycle reading byte 80.
    mcycle(OP_WRITE, 16'hFF46, 8'hC1);
    mcycle(OP_IDLE, 16'h0000, 8'h00);
    for (int i = 0; i < 80; i++) mcycle(OP_IDLE, 16'h0000, 8'h00);
    @(negedge clk);
    chk("pre_reset_addr", mem_addr, 16'hC150);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("midrst_hold");
    release_reset();
    n_oam = 0; n_act = 0;
    for (int i = 0; i < 170; i++) mcycle(OP_IDLE, 16'h0000, 8'h00);
    chk("no_oam_after_reset", n_oam, 0);
    chk("no_dma_after_reset", n_act, 0);

    // Randomized traffic including occasional DMA triggers.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        mcycle(OP_WRITE, 16'hFF46, 8'($urandom_range(0, 255)));
      end else begin
        rop = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0, 1: raddr = 16'($urandom_range(0, 16'hFF7F));
          2: raddr = 16'hFF80 + 16'($urandom_range(0, 127));
          default: raddr = (rop == OP_WRITE) ? 16'hFF47 : 16'hFF46;
        endcase
        mcycle(rop, raddr, 8'($urandom_range(0, 255)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gb_bus_arbiter.md
Name: gb_bus_arbiter

Overview:
- Sits between the CPU core and the system memory buses.
- Generates the T-cycle phase that frames each 4-clock M-cycle, and routes each CPU access (bus_opcode_t from cpu_pkg) to either the main bus or HRAM.
- Owns the OAM DMA engine (register FF46), which takes over the main bus for 160 M-cycles.
- During DMA, only HRAM (FF80–FFFE) and FF46 stay accessible to the CPU.

Parameters:
- DMA_LEN, 160, number of bytes per OAM DMA transfer.
- DMA_REG_ADDR, 16'hFF46, address of the DMA source/trigger register.

Ports:
- clk  in  1  system clock (one T-cycle per clock)
- rst_n  in  1  asynchronous active-low reset
- t_phase  out  2  current T-cycle within the M-cycle (0..3)
- cpu_op  in  3  bus_opcode_t; held constant for the whole M-cycle
- cpu_addr  in  16  CPU access address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data (registered)
- cpu_rvalid  out  1  one-clock pulse: cpu_rdata updated
- mem_addr  out  16  main bus address
- mem_rd  out  1  main bus read strobe
- mem_wr  out  1  main bus write strobe
- mem_wdata  out  8  main bus write data
- mem_rdata  in  8  main bus read data
- hram_addr  out  7  HRAM offset (addr − FF80)
- hram_rd  out  1  HRAM read strobe
- hram_we  out  1  HRAM write strobe
- hram_wdata  out  8  HRAM write data
- hram_rdata  in  8  HRAM read data
- oam_we  out  1  OAM write pulse from DMA
- oam_addr  out  8  OAM byte index
- oam_wdata  out  8  OAM write data
- dma_active  out  1  DMA owns the main bus this M-cycle

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values:
  - t_phase=0, cpu_rdata=8'hFF, cpu_rvalid=0.
  - dma_reg=8'hFF, dma_active=0, dma state IDLE, dma_idx=0.
  - oam_we=0, oam_addr=0, oam_wdata=0.
  - All strobes low.
- Reset mid-transfer aborts the DMA immediately. No OAM write follows the deassertion of reset.
- t_phase: free-running 0→1→2→3→0 after reset. An M-cycle is phases 0..3.
- CPU access classes:
  - IF, IF_CB and READ are reads; WRITE is a write; IDLE means no access.
  - Unknown encodings are treated as IDLE.
- Routing (combinational from cpu_* and DMA state, every phase of the M-cycle):
  - addr==DMA_REG_ADDR: internal register. Reads return dma_reg. A write loads dma_reg at the clock edge ending phase 3. Never forwarded to any bus.
  - FF80 ≤ addr ≤ FFFE: HRAM port. hram_rd is high phases 0–3 for reads. hram_we is high in phase 2 only for writes.
  - Otherwise, with dma_active=0: main bus. mem_addr=cpu_addr. mem_rd is high phases 0–3 for reads. mem_wr is high in phase 2 only, with mem_wdata=cpu_wdata.
  - Otherwise, with dma_active=1: blocked. No strobe. Read data is 8'hFF. Writes are dropped.
- Read completion:
  - At the edge ending phase 3, cpu_rdata captures the selected source.
  - cpu_rvalid is high for the single phase-0 clock that follows.
  - IDLE and WRITE leave cpu_rdata unchanged, with no rvalid.
- DMA FSM, states IDLE → SETUP → RUN:
  - Trigger: a CPU write to FF46 in M-cycle k, in any state, goes to SETUP at the k/k+1 boundary with dma_idx=0.
  - SETUP lasts one M-cycle (k+1) with dma_active=0.
  - RUN covers M-cycles k+2..k+1+DMA_LEN, with dma_active=1.
  - In RUN: mem_addr={dma_reg,dma_idx}, mem_rd high phases 0–3, mem_wr=0.
  - At the edge ending phase 3, the byte is captured into oam_wdata with oam_addr=dma_idx, and dma_idx increments.
  - oam_we is a one-clock pulse in phase 0 of the next M-cycle. The final pulse lands in M-cycle k+2+DMA_LEN, after which the FSM is back in IDLE.
  - dma_reg is not modified by the engine. The source high byte is used unmodified (no echo remapping).
- Retrigger: a write to FF46 during RUN restarts SETUP with the new source and dma_idx=0.
  - dma_active drops for that SETUP M-cycle.
  - The pending OAM write of the last byte read still issues.
- Simultaneous events:
  - A CPU HRAM access and a DMA main-bus read in the same M-cycle both proceed.
  - A CPU read of FF46 during RUN returns dma_reg.
- All dma_active and ownership changes occur only at M-cycle boundaries (edge ending phase 3).

Test Plan:
- Reset release, then READ at 0x0150 with mem_rdata=8'h3E → mem_rd high phases 0–3; cpu_rdata=8'h3E with a cpu_rvalid pulse at the next phase 0.
- WRITE 8'h5A to 0xC000 → mem_wr high only in phase 2 with mem_wdata=8'h5A; no cpu_rvalid.
- WRITE 8'hC1 to FF46 with the bus model returning (addr[7:0]^8'hA5):
  - 1 setup M-cycle, then 160 M-cycles with mem_addr C100..C19F.
  - 160 oam_we pulses, oam_addr 0..159 and matching data.
  - dma_active high exactly 160 M-cycles.
- During RUN:
  - READ 0x8000 → cpu_rdata=8'hFF with no CPU-driven mem_rd.
  - WRITE 0xFF90=8'h77 → hram_we in phase 2 with hram_addr=7'h10.
  - READ FF46 → 8'hC1.
- Retrigger with FF46=8'hD0 at dma_idx=50 → the byte-49 OAM write still occurs, one M-cycle with dma_active=0, then reads restart at D000.
- Assert rst_n low at dma_idx=80, mid phase 1 → all outputs at reset values immediately; no further oam_we after release.
